// File: rtl/uart_pkg.sv
// Shared definitions for the host-side UART transmitter.
//   tx_state_t   : transmitter FSM states
//   DATA_BITS    : payload bits per frame
//   frame_cycles : clock cycles occupied by one complete frame
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int DATA_BITS = 8;

   // start bit + data bits + stop bits, each clks_per_bit long
   function automatic int frame_cycles(input int clks_per_bit, input int stop_bits);
      return (1 + DATA_BITS + stop_bits) * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_host_tx_fifo.sv
// Byte FIFO with first-word fall-through head.
// Ports:
//   clk, resb : clock, async active-low reset
//   push, din : write request and byte (ignored when full, even alongside a pop)
//   pop       : read request (ignored when empty)
//   dout      : head byte, valid whenever !empty
//   full, empty, count : registered occupancy flags and count
module byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resb,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_full;
   logic          r_empty;
   logic          w_push_ok;
   logic          w_pop_ok;
   logic [AW:0]   w_count_next;

   assign w_push_ok = push && !r_full;
   assign w_pop_ok  = pop && !r_empty;

   always_comb begin
      w_count_next = r_count;
      if (w_push_ok && !w_pop_ok)
         w_count_next = r_count + (AW+1)'(1);
      else if (w_pop_ok && !w_push_ok)
         w_count_next = r_count - (AW+1)'(1);
   end

   // storage needs no reset; emptiness is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= din;
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_next;
         r_full  <= (w_count_next == (AW+1)'(DEPTH));
         r_empty <= (w_count_next == '0);
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = r_full;
   assign empty = r_empty;
   assign count = r_count;

endmodule

// File: rtl/uart_host_tx.sv
// Host-side 8N1/8N2 serial transmitter driving the ACIA rxd line.
// Ports:
//   clk, resb        : ACIA bit clock, async active-low reset
//   in_data/in_valid : byte input, accepted when in_valid && in_ready
//   in_ready         : FIFO not full
//   txd              : serial line, idle high, registered
//   busy             : frame on the line or bytes pending
//   fifo_count       : FIFO occupancy
//   frame_done       : one-cycle pulse on the last stop-period cycle
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for one bit time
// DATA  | 8 data bits, LSB first
// STOP  | stop period (high); back-to-back start if more data queued
module uart_host_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                          clk,
   input  logic                          resb,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_done
);

   localparam int TW          = $clog2(CLKS_PER_BIT*2);
   localparam int STOP_CYCLES = frame_cycles(CLKS_PER_BIT, STOP_BITS) - (1 + DATA_BITS) * CLKS_PER_BIT;
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] STOP_LAST = TW'(STOP_CYCLES - 1);

   tx_state_t  r_state, w_state_next;
   logic [TW-1:0] r_timer, w_timer_next;
   logic [2:0] r_bit_idx, w_bit_idx_next;
   logic [7:0] r_shift, w_shift_next;
   logic       r_txd, w_txd_next;
   logic       r_frame_done;
   logic       w_timer_tc;
   logic       w_pop;
   logic [7:0] w_fifo_dout;
   logic       w_fifo_full;
   logic       w_fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .resb  (resb),
      .push  (in_valid),
      .din   (in_data),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (w_fifo_count)
   );

   // the whole stop period is timed as one span so 2 stop bits need no extra state
   assign w_timer_tc = (r_state == STOP) ? (r_timer == STOP_LAST) : (r_timer == BIT_LAST);

   // txd is computed for the next cycle and registered so the line never glitches
   always_comb begin
      w_state_next   = r_state;
      w_timer_next   = r_timer + TW'(1);
      w_bit_idx_next = r_bit_idx;
      w_shift_next   = r_shift;
      w_txd_next     = 1'b1;
      w_pop          = 1'b0;
      case (r_state)
         IDLE: begin
            w_timer_next = '0;
            if (!w_fifo_empty) begin
               w_pop          = 1'b1;
               w_shift_next   = w_fifo_dout;
               w_bit_idx_next = '0;
               w_state_next   = START;
               w_txd_next     = 1'b0;
            end
         end
         START: begin
            w_txd_next = 1'b0;
            if (w_timer_tc) begin
               w_timer_next = '0;
               w_state_next = DATA;
               w_txd_next   = r_shift[0];
            end
         end
         DATA: begin
            w_txd_next = r_shift[0];
            if (w_timer_tc) begin
               w_timer_next = '0;
               if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                  w_state_next = STOP;
                  w_txd_next   = 1'b1;
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
                  w_shift_next   = {1'b0, r_shift[7:1]};
                  w_txd_next     = r_shift[1];
               end
            end
         end
         STOP: begin
            if (w_timer_tc) begin
               w_timer_next = '0;
               if (!w_fifo_empty) begin
                  w_pop          = 1'b1;
                  w_shift_next   = w_fifo_dout;
                  w_bit_idx_next = '0;
                  w_state_next   = START;
                  w_txd_next     = 1'b0;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
            w_timer_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         r_state      <= IDLE;
         r_timer      <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_txd        <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_timer      <= w_timer_next;
         r_bit_idx    <= w_bit_idx_next;
         r_shift      <= w_shift_next;
         r_txd        <= w_txd_next;
         // registered one edge early so the pulse lands on the final stop cycle
         r_frame_done <= (w_state_next == STOP) && (w_timer_next == STOP_LAST);
      end
   end

   assign in_ready   = !w_fifo_full;
   assign txd        = r_txd;
   assign busy       = (r_state != IDLE) || (w_fifo_count != '0);
   assign fifo_count = w_fifo_count;
   assign frame_done = r_frame_done;

endmodule
